// File: rtl/regfile_writeback_if.sv
// Producer-side handshake bundle for the register-file writeback unit:
// one valid/ready channel from the load unit and one from the ALU.
interface regfile_writeback_if #(
    parameter int XLEN = 32
);
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_dest;
    logic [XLEN-1:0] mem_data;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_dest;
    logic [XLEN-1:0] alu_data;

    modport master (
        output mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data,
        input  mem_ready, alu_ready
    );

    modport slave (
        input  mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data,
        output mem_ready, alu_ready
    );
endinterface

// File: rtl/regfile_writeback.sv
// In-order writeback queue feeding the register file's single write port.
// Optional same-cycle bypass into an empty queue: define REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    regfile_writeback_if.slave         wb,
    output logic                       rf_load_o,
    output logic [4:0]                 rf_dest_o,
    output logic [XLEN-1:0]            rf_in_o,
    output logic [31:0]                pend_mask_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]      dest_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic          empty;
    logic [CW:0]   free;
    logic          mem_fire, alu_fire, mem_push, alu_push;
    logic          byp_mem, byp_alu, mem_enq, alu_enq;

    assign empty = (count_q == '0);
    // The head always retires this cycle, so its slot counts as free.
    assign free  = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, !empty};

    assign wb.mem_ready = rst_ni && (free >= (CW+1)'(1));
    assign wb.alu_ready = rst_ni && ((free >= (CW+1)'(2)) ||
                                     ((free >= (CW+1)'(1)) && !wb.mem_valid));

    assign mem_fire = wb.mem_valid && wb.mem_ready;
    assign alu_fire = wb.alu_valid && wb.alu_ready;
    assign mem_push = mem_fire && (wb.mem_dest != 5'd0);
    assign alu_push = alu_fire && (wb.alu_dest != 5'd0);

`ifdef REGFILE_WB_BYPASS_EN
    // A valid mem result wins the bypass even when it targets x0.
    assign byp_mem = empty && mem_push;
    assign byp_alu = empty && !wb.mem_valid && alu_push;
`else
    assign byp_mem = 1'b0;
    assign byp_alu = 1'b0;
`endif

    assign mem_enq = mem_push && !byp_mem;
    assign alu_enq = alu_push && !byp_alu;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(mem_enq) + AW'(alu_enq);
        rd_ptr_d = rd_ptr_q + AW'(!empty);
        count_d  = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(!empty);
    end

    // Mem takes the first free slot so it retires ahead of a same-edge ALU result.
    always_ff @(posedge clk_i) begin
        if (mem_enq) begin
            dest_q[wr_ptr_q] <= wb.mem_dest;
            data_q[wr_ptr_q] <= wb.mem_data;
        end
        if (alu_enq) begin
            dest_q[wr_ptr_q + AW'(mem_enq)] <= wb.alu_dest;
            data_q[wr_ptr_q + AW'(mem_enq)] <= wb.alu_data;
        end
    end

    always_comb begin
        rf_load_o = 1'b0;
        rf_dest_o = 5'd0;
        rf_in_o   = '0;
        if (!empty) begin
            rf_load_o = 1'b1;
            rf_dest_o = dest_q[rd_ptr_q];
            rf_in_o   = data_q[rd_ptr_q];
        end else if (byp_mem) begin
            rf_load_o = 1'b1;
            rf_dest_o = wb.mem_dest;
            rf_in_o   = wb.mem_data;
        end else if (byp_alu) begin
            rf_load_o = 1'b1;
            rf_dest_o = wb.alu_dest;
            rf_in_o   = wb.alu_data;
        end
    end

    always_comb begin
        logic [AW-1:0] off;
        pend_mask_o = '0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) pend_mask_o[dest_q[i]] = 1'b1;
        end
        if (byp_mem) pend_mask_o[wb.mem_dest] = 1'b1;
        if (byp_alu) pend_mask_o[wb.alu_dest] = 1'b1;
    end

    assign count_o = count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a scoreboard of pending writes.
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [31:0] pend_mask;
    logic [2:0]  count;

    int   n_assert = 0;
    int   n_fail   = 0;
    ent_t sb[$];

    regfile_writeback_if #(.XLEN(XLEN)) wb();

    regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wb          (wb.slave),
        .rf_load_o   (rf_load),
        .rf_dest_o   (rf_dest),
        .rf_in_o     (rf_in),
        .pend_mask_o (pend_mask),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare DUT against the scoreboard model mid-cycle, then
    // apply the model's retire/accept on the rising edge.
    task automatic step(output logic alu_acc);
        int          n;
        logic [31:0] pm;
        logic [5:0]  fr;
        logic        mr, ar;
        logic [4:0]  ed;
        logic [31:0] ev;
        @(negedge clk);
        n  = sb.size();
        pm = '0;
        foreach (sb[i]) pm[sb[i].d] = 1'b1;
        fr = 6'(DEPTH - n + ((n != 0) ? 1 : 0));
        mr = (fr >= 6'd1);
        ar = (fr >= 6'd2) || ((fr >= 6'd1) && !wb.mem_valid);
        ed = 5'd0;
        ev = 32'd0;
        if (n != 0) begin
            ed = sb[0].d;
            ev = sb[0].v;
        end
        chk("count",     64'(count),     64'(n));
        chk("rf_load",   64'(rf_load),   64'(n != 0));
        chk("rf_dest",   64'(rf_dest),   64'(ed));
        chk("rf_in",     64'(rf_in),     64'(ev));
        chk("pend_mask", 64'(pend_mask), 64'(pm));
        chk("mem_ready", 64'(wb.mem_ready), 64'(mr));
        chk("alu_ready", 64'(wb.alu_ready), 64'(ar));
        @(posedge clk);
        alu_acc = wb.alu_valid && ar;
        if (n != 0) void'(sb.pop_front());
        if (wb.mem_valid && mr && wb.mem_dest != 5'd0) sb.push_back('{wb.mem_dest, wb.mem_data});
        if (alu_acc && wb.alu_dest != 5'd0) sb.push_back('{wb.alu_dest, wb.alu_data});
        #1;
    endtask

    task automatic idle();
        wb.mem_valid = 1'b0;
        wb.alu_valid = 1'b0;
        wb.mem_dest  = 5'd0;
        wb.alu_dest  = 5'd0;
        wb.mem_data  = '0;
        wb.alu_data  = '0;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(a);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        step(a);
    endtask

    initial begin
        logic a;
        idle();
        rst_n = 1'b0;
        wb.mem_valid = 1'b1;
        wb.alu_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",     64'(count),        64'd0);
        chk("rst_rf_load",   64'(rf_load),      64'd0);
        chk("rst_pend",      64'(pend_mask),    64'd0);
        chk("rst_mem_ready", 64'(wb.mem_ready), 64'd0);
        chk("rst_alu_ready", 64'(wb.alu_ready), 64'd0);
        idle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_mem_ready", 64'(wb.mem_ready), 64'd1);
        chk("post_rst_alu_ready", 64'(wb.alu_ready), 64'd1);
        @(posedge clk);
        #1;

`ifdef REGFILE_WB_BYPASS_EN
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 5'd7;
        wb.alu_data  = 32'h1234;
        #1;
        chk("byp_rf_load", 64'(rf_load),   64'd1);
        chk("byp_rf_dest", 64'(rf_dest),   64'd7);
        chk("byp_rf_in",   64'(rf_in),     64'h1234);
        chk("byp_pend",    64'(pend_mask), 64'h80);
        chk("byp_count",   64'(count),     64'd0);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("byp_after_count",   64'(count),   64'd0);
        chk("byp_after_rf_load", 64'(rf_load), 64'd0);
`else
        // Single ALU write
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 5'd5;
        wb.alu_data  = 32'hDEADBEEF;
        step(a);
        chk("t1_accept", 64'(a), 64'd1);
        idle();
        @(negedge clk);
        chk("t1_rf_dest", 64'(rf_dest),   64'd5);
        chk("t1_rf_in",   64'(rf_in),     64'hDEADBEEF);
        chk("t1_pend",    64'(pend_mask), 64'h20);
        @(posedge clk);
        void'(sb.pop_front());
        #1;
        step(a);

        // Same-edge mem and ALU to x3: mem value retires first
        wb.mem_valid = 1'b1; wb.mem_dest = 5'd3; wb.mem_data = 32'h11;
        wb.alu_valid = 1'b1; wb.alu_dest = 5'd3; wb.alu_data = 32'h22;
        step(a);
        idle();
        drain();

        // Mem streams dest 1..6 while ALU contends; queue never overflows
        wb.alu_valid = 1'b1;
        wb.alu_dest  = 5'd9;
        wb.alu_data  = 32'h900;
        for (int k = 1; k <= 6; k++) begin
            wb.mem_valid = 1'b1;
            wb.mem_dest  = 5'(k);
            wb.mem_data  = 32'h100 + 32'(k);
            step(a);
            if (a) wb.alu_data = wb.alu_data + 32'd1;
        end
        idle();
        drain();

        // Mem write to x0 is accepted and discarded
        wb.mem_valid = 1'b1;
        wb.mem_dest  = 5'd0;
        wb.mem_data  = 32'hFFFFFFFF;
        step(a);
        idle();
        step(a);
        chk("x0_count", 64'(count), 64'd0);

        // Queue three entries, then reset mid-cycle
        wb.mem_valid = 1'b1; wb.mem_dest = 5'd10; wb.mem_data = 32'hA0;
        wb.alu_valid = 1'b1; wb.alu_dest = 5'd11; wb.alu_data = 32'hB0;
        step(a);
        wb.mem_dest = 5'd12; wb.mem_data = 32'hA1;
        wb.alu_dest = 5'd13; wb.alu_data = 32'hB1;
        step(a);
        idle();
        chk("pre_rst_count", 64'(count), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rf_load",   64'(rf_load),      64'd0);
        chk("mid_rst_count",     64'(count),        64'd0);
        chk("mid_rst_pend",      64'(pend_mask),    64'd0);
        chk("mid_rst_mem_ready", 64'(wb.mem_ready), 64'd0);
        sb.delete();
        #2;
        rst_n = 1'b1;
        repeat (4) step(a);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
